// File: rtl/mul_seq_unit_if.sv
// Operand/result bundle for the sequential multiplier.
// start is sampled only while busy is low; done pulses once per accepted start.
interface mul_seq_unit_if;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, is_signed, op_a, op_b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, op_a, op_b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_seq_unit.sv
// Multi-cycle 32x32->64 MULT/MULTU unit built around one time-shared ripple adder.
// Fixed 36-cycle latency: abs(a), abs(b), 32 shift-add steps, two-step result negation.

module thirtytwo_bit_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  logic [32:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[32];
endmodule

module mux2x1_32bit (
  input  logic        sel,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  output logic [31:0] y
);
  assign y = sel ? d1 : d0;
endmodule

module mul_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  mul_seq_unit_if.slave bus,
  output logic [2:0]  state_dbg
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABS_A  = 3'd1,
    ABS_B  = 3'd2,
    MUL    = 3'd3,
    FIX_LO = 3'd4,
    FIX_HI = 3'd5
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_r, b_r, mcand, p_hi, p_lo, r_lo, hi_r, lo_r;
  logic             sgn_r, neg_r, k_r, done_r;
  // Thermometer iteration count: bit i set once i+1 MUL steps are done.
  logic [30:0]      cnt;

  logic        is_mul, is_abs, is_abs_b, is_fix_hi, add_cin, add_cout;
  logic [31:0] neg_ab, neg_p, neg_src, add_x, add_y, add_s;
  logic        mul_c;
  logic [31:0] mul_s;

  assign is_mul    = (state == MUL);
  assign is_abs    = (state == ABS_A) || (state == ABS_B);
  assign is_abs_b  = (state == ABS_B);
  assign is_fix_hi = (state == FIX_HI);

  // Negation steps feed ~x + 0 + cin; MUL feeds P_hi + mcand.
  mux2x1_32bit u_mux_ab   (.sel(is_abs_b),  .d0(~a_r),    .d1(~b_r),   .y(neg_ab));
  mux2x1_32bit u_mux_p    (.sel(is_fix_hi), .d0(~p_lo),   .d1(~p_hi),  .y(neg_p));
  mux2x1_32bit u_mux_neg  (.sel(is_abs),    .d0(neg_p),   .d1(neg_ab), .y(neg_src));
  mux2x1_32bit u_mux_x    (.sel(is_mul),    .d0(neg_src), .d1(p_hi),   .y(add_x));
  mux2x1_32bit u_mux_y    (.sel(is_mul),    .d0(32'd0),   .d1(mcand),  .y(add_y));

  thirtytwo_bit_adder u_add (
    .a(add_x), .b(add_y), .cin(add_cin), .s(add_s), .cout(add_cout)
  );

  always_comb begin
    add_cin = 1'b0;
    case (state)
      ABS_A, ABS_B, FIX_LO: add_cin = 1'b1;
      FIX_HI:               add_cin = k_r;
      default:              add_cin = 1'b0;
    endcase
  end

  always_comb begin
    mul_c = 1'b0;
    mul_s = p_hi;
    if (p_lo[0]) begin
      mul_c = add_cout;
      mul_s = add_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = ABS_A;
      ABS_A:   state_n = ABS_B;
      ABS_B:   state_n = MUL;
      MUL:     if (cnt[30]) state_n = FIX_LO;
      FIX_LO:  state_n = FIX_HI;
      FIX_HI:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r    <= '0;
      b_r    <= '0;
      sgn_r  <= 1'b0;
      neg_r  <= 1'b0;
      mcand  <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      cnt    <= '0;
      r_lo   <= '0;
      k_r    <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= is_fix_hi;
      case (state)
        IDLE: if (bus.start) begin
          a_r   <= bus.op_a;
          b_r   <= bus.op_b;
          sgn_r <= bus.is_signed;
          neg_r <= bus.is_signed & (bus.op_a[31] ^ bus.op_b[31]);
        end
        ABS_A: mcand <= (sgn_r & a_r[31]) ? add_s : a_r;
        ABS_B: begin
          p_lo <= (sgn_r & b_r[31]) ? add_s : b_r;
          p_hi <= '0;
          cnt  <= '0;
        end
        MUL: begin
          p_hi <= {mul_c, mul_s[31:1]};
          p_lo <= {mul_s[0], p_lo[31:1]};
          cnt  <= {cnt[29:0], 1'b1};
        end
        FIX_LO: begin
          if (neg_r) begin
            {k_r, r_lo} <= {add_cout, add_s};
          end else begin
            r_lo <= p_lo;
            k_r  <= 1'b0;
          end
        end
        FIX_HI: begin
          hi_r <= neg_r ? add_s : p_hi;
          lo_r <= r_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign state_dbg = state;
endmodule
